// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the stall/flush controls returned to them.
// master = pipeline side (drives hazard info), slave = the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [2:0]           id_alu_rn;
    logic [2:0]           id_alu_rm;
    logic [2:0]           id_mem_rn;
    logic [2:0]           id_mem_rd;
    logic [3:0]           id_src_valid;
    logic                 p2_memRead;
    logic [2:0]           p2_mem_rd;
    logic                 ex_redirect;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 if_id_write;
    logic                 id_ex_write;
    logic                 ex_mem_write;
    logic                 mem_wb_write;
    logic                 IF_flush;
    logic                 ID_flush;
    logic                 EX_flush;
    logic                 p2_pipeline_stall;
    logic [1:0]           ctrl_state;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;
    logic                 mem_timeout;

    modport master (
        output id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd, id_src_valid,
        output p2_memRead, p2_mem_rd, ex_redirect, mem_req, mem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        input  IF_flush, ID_flush, EX_flush, p2_pipeline_stall,
        input  ctrl_state, stall_count, flush_count, mem_timeout
    );

    modport slave (
        input  id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd, id_src_valid,
        input  p2_memRead, p2_mem_rd, ex_redirect, mem_req, mem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        output IF_flush, ID_flush, EX_flush, p2_pipeline_stall,
        output ctrl_state, stall_count, flush_count, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the IF/ID, ID/EX, EX/MEM, MEM/WB registers; controls are zero-latency
// combinational from hazards + state, a pending memory access freezes the whole pipe until mem_ready.
module pipeline_hazard_ctrl #(
    parameter int INIT_FLUSH_CYCLES = 4,
    parameter int FREEZE_TIMEOUT    = 255,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int INIT_LOAD = (INIT_FLUSH_CYCLES < 1) ? 1 : INIT_FLUSH_CYCLES;
    localparam int INIT_W    = $clog2(INIT_LOAD + 1);
    localparam int FRZ_LIM   = (FREEZE_TIMEOUT < 1) ? 1 : FREEZE_TIMEOUT;
    localparam int FRZ_W     = $clog2(FRZ_LIM + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_INIT,
        M_FREEZE,
        M_RESOLVE
    } mode_e;

    state_e               state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic [FRZ_W-1:0]     freeze_cnt_q, freeze_cnt_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
    logic                 mem_timeout_q, mem_timeout_d;
    mode_e                mode;

    logic load_use;
    logic res_pc_write, res_if_id_write, res_if_flush, res_id_flush, res_bubble;
    logic res_stall_inc, res_flush_inc;

    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_flush, id_flush, ex_flush, bubble;
    logic stall_inc, flush_inc;

    // Every enabled source is compared, r0 included.
    assign load_use = hz.p2_memRead &&
                      ((hz.id_src_valid[0] && (hz.id_alu_rn == hz.p2_mem_rd)) ||
                       (hz.id_src_valid[1] && (hz.id_alu_rm == hz.p2_mem_rd)) ||
                       (hz.id_src_valid[2] && (hz.id_mem_rn == hz.p2_mem_rd)) ||
                       (hz.id_src_valid[3] && (hz.id_mem_rd == hz.p2_mem_rd)));

    // Redirect beats load-use: the stalled ID bundle is squashed anyway.
    always_comb begin
        res_pc_write    = 1'b1;
        res_if_id_write = 1'b1;
        res_if_flush    = 1'b0;
        res_id_flush    = 1'b0;
        res_bubble      = 1'b0;
        res_stall_inc   = 1'b0;
        res_flush_inc   = 1'b0;
        if (hz.ex_redirect) begin
            res_if_flush  = 1'b1;
            res_id_flush  = 1'b1;
            res_flush_inc = 1'b1;
        end else if (load_use) begin
            res_pc_write    = 1'b0;
            res_if_id_write = 1'b0;
            res_bubble      = 1'b1;
            res_stall_inc   = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        freeze_cnt_d  = freeze_cnt_q;
        mem_timeout_d = mem_timeout_q;
        mode          = M_INIT;
        case (state_q)
            ST_INIT: begin
                mode       = M_INIT;
                init_cnt_d = init_cnt_q - 1'b1;
                if (init_cnt_q <= INIT_W'(1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = INIT_W'(INIT_LOAD);
                end
            end
            ST_RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    mode         = M_FREEZE;
                    state_d      = ST_FREEZE;
                    freeze_cnt_d = '0;
                end else begin
                    mode = M_RESOLVE;
                end
            end
            ST_FREEZE: begin
                if (!hz.mem_ready) begin
                    mode = M_FREEZE;
                    if (freeze_cnt_q != FRZ_W'(FRZ_LIM)) begin
                        freeze_cnt_d = freeze_cnt_q + 1'b1;
                    end
                    if (freeze_cnt_d == FRZ_W'(FRZ_LIM)) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    mode         = M_RESOLVE;
                    state_d      = ST_RUN;
                    freeze_cnt_d = '0;
                end
            end
            default: begin
                mode       = M_INIT;
                state_d    = ST_INIT;
                init_cnt_d = INIT_W'(INIT_LOAD);
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_flush     = 1'b1;
        id_flush     = 1'b1;
        ex_flush     = 1'b1;
        bubble       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (mode)
            M_FREEZE: begin
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
                if_flush     = 1'b0;
                id_flush     = 1'b0;
                ex_flush     = 1'b0;
                stall_inc    = 1'b1;
            end
            M_RESOLVE: begin
                pc_write    = res_pc_write;
                if_id_write = res_if_id_write;
                if_flush    = res_if_flush;
                id_flush    = res_id_flush;
                ex_flush    = 1'b0;
                bubble      = res_bubble;
                stall_inc   = res_stall_inc;
                flush_inc   = res_flush_inc;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_inc && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (flush_inc && (flush_count_q != {CNT_WIDTH{1'b1}})) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= INIT_W'(INIT_LOAD);
            freeze_cnt_q  <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            freeze_cnt_q  <= freeze_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hz.pc_write          = pc_write;
    assign hz.if_id_write       = if_id_write;
    assign hz.id_ex_write       = id_ex_write;
    assign hz.ex_mem_write      = ex_mem_write;
    assign hz.mem_wb_write      = mem_wb_write;
    assign hz.IF_flush          = if_flush;
    assign hz.ID_flush          = id_flush;
    assign hz.EX_flush          = ex_flush;
    assign hz.p2_pipeline_stall = bubble;
    assign hz.ctrl_state        = state_q;
    assign hz.stall_count       = stall_count_q;
    assign hz.flush_count       = flush_count_q;
    assign hz.mem_timeout       = mem_timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: INIT window, load-use, redirect, freeze/timeout, reset, saturation.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // {pc_write, if_id, id_ex, ex_mem, mem_wb, IF_flush, ID_flush, EX_flush, p2_pipeline_stall}
    localparam logic [8:0] C_INIT   = 9'b0_1111_111_0;
    localparam logic [8:0] C_NORMAL = 9'b1_1111_000_0;
    localparam logic [8:0] C_FREEZE = 9'b0_0000_000_0;
    localparam logic [8:0] C_REDIR  = 9'b1_1111_110_0;
    localparam logic [8:0] C_LDUSE  = 9'b0_0111_000_1;

    pipeline_hazard_ctrl_if #(.CNT_WIDTH(16)) hz ();

    pipeline_hazard_ctrl #(
        .INIT_FLUSH_CYCLES(4),
        .FREEZE_TIMEOUT   (8),
        .CNT_WIDTH        (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_vec();
        return {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write, hz.mem_wb_write,
                hz.IF_flush, hz.ID_flush, hz.EX_flush, hz.p2_pipeline_stall};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_alu_rn    = 3'd0;
        hz.id_alu_rm    = 3'd0;
        hz.id_mem_rn    = 3'd0;
        hz.id_mem_rd    = 3'd0;
        hz.id_src_valid = 4'b0000;
        hz.p2_memRead   = 1'b0;
        hz.p2_mem_rd    = 3'd0;
        hz.ex_redirect  = 1'b0;
        hz.mem_req      = 1'b0;
        hz.mem_ready    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("reset_ctrl", 32'(ctrl_vec()), 32'(C_INIT));
        chk("reset_state", 32'(hz.ctrl_state), 32'd0);
        chk("reset_stall_cnt", 32'(hz.stall_count), 32'd0);
        chk("reset_flush_cnt", 32'(hz.flush_count), 32'd0);
        chk("reset_timeout", 32'(hz.mem_timeout), 32'd0);

        // Four INIT cycles after release, RUN on the fifth.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("init_ctrl", 32'(ctrl_vec()), 32'(C_INIT));
            chk("init_state", 32'(hz.ctrl_state), 32'd0);
            tick();
        end
        #1;
        chk("run_state", 32'(hz.ctrl_state), 32'd1);
        chk("run_ctrl", 32'(ctrl_vec()), 32'(C_NORMAL));
        chk("run_stall_cnt", 32'(hz.stall_count), 32'd0);

        // Load-use on alu_rm.
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd3; hz.id_alu_rm = 3'd3; hz.id_src_valid = 4'b0010;
        #1;
        chk("lduse_ctrl", 32'(ctrl_vec()), 32'(C_LDUSE));
        tick();
        clear_inputs();
        #1;
        chk("lduse_after_ctrl", 32'(ctrl_vec()), 32'(C_NORMAL));
        chk("lduse_stall_cnt", 32'(hz.stall_count), 32'd1);

        // Same load, no enabled sources.
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd3; hz.id_alu_rm = 3'd3; hz.id_src_valid = 4'b0000;
        #1;
        chk("novalid_ctrl", 32'(ctrl_vec()), 32'(C_NORMAL));
        tick();
        clear_inputs();
        #1;
        chk("novalid_stall_cnt", 32'(hz.stall_count), 32'd1);

        // Store-data source match.
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd5; hz.id_mem_rd = 3'd5; hz.id_src_valid = 4'b1000;
        #1;
        chk("lduse_memrd_ctrl", 32'(ctrl_vec()), 32'(C_LDUSE));
        tick();
        clear_inputs();
        // r0 counts like any other register.
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd0; hz.id_mem_rn = 3'd0; hz.id_src_valid = 4'b0100;
        #1;
        chk("lduse_r0_ctrl", 32'(ctrl_vec()), 32'(C_LDUSE));
        tick();
        clear_inputs();
        // Enabled alu_rn that does not match.
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd2; hz.id_alu_rn = 3'd6; hz.id_src_valid = 4'b0001;
        #1;
        chk("nomatch_ctrl", 32'(ctrl_vec()), 32'(C_NORMAL));
        tick();
        clear_inputs();
        #1;
        chk("lduse3_stall_cnt", 32'(hz.stall_count), 32'd3);

        // Redirect together with load-use: redirect only.
        hz.ex_redirect = 1'b1;
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd3; hz.id_alu_rm = 3'd3; hz.id_src_valid = 4'b0010;
        #1;
        chk("redir_lduse_ctrl", 32'(ctrl_vec()), 32'(C_REDIR));
        tick();
        clear_inputs();
        #1;
        chk("redir_flush_cnt", 32'(hz.flush_count), 32'd1);
        chk("redir_stall_cnt", 32'(hz.stall_count), 32'd3);

        // Freeze 3 cycles with a pending redirect, redirect taken on exit.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_ctrl", 32'(ctrl_vec()), 32'(C_FREEZE));
            chk("freeze_state", 32'(hz.ctrl_state), (i == 0) ? 32'd1 : 32'd2);
            tick();
        end
        hz.mem_ready = 1'b1;
        #1;
        chk("freeze_exit_ctrl", 32'(ctrl_vec()), 32'(C_REDIR));
        chk("freeze_exit_stall_cnt", 32'(hz.stall_count), 32'd6);
        tick();
        clear_inputs();
        #1;
        chk("post_freeze_state", 32'(hz.ctrl_state), 32'd1);
        chk("post_freeze_flush_cnt", 32'(hz.flush_count), 32'd2);
        chk("post_freeze_stall_cnt", 32'(hz.stall_count), 32'd6);
        chk("post_freeze_timeout", 32'(hz.mem_timeout), 32'd0);

        // 10 frozen cycles: entry in RUN then 9 FREEZE cycles; flag rises after the 8th FREEZE cycle.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk("timeout_ctrl", 32'(ctrl_vec()), 32'(C_FREEZE));
            chk("timeout_flag", 32'(hz.mem_timeout), (i >= 10) ? 32'd1 : 32'd0);
            tick();
        end
        hz.mem_ready = 1'b1;
        #1;
        chk("timeout_exit_ctrl", 32'(ctrl_vec()), 32'(C_NORMAL));
        tick();
        clear_inputs();
        #1;
        chk("timeout_exit_state", 32'(hz.ctrl_state), 32'd1);
        chk("timeout_sticky", 32'(hz.mem_timeout), 32'd1);
        chk("timeout_stall_cnt", 32'(hz.stall_count), 32'd16);

        // Reset asserted mid-FREEZE.
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        tick();
        #1;
        chk("pre_reset_state", 32'(hz.ctrl_state), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_reset_state", 32'(hz.ctrl_state), 32'd0);
        chk("mid_reset_ctrl", 32'(ctrl_vec()), 32'(C_INIT));
        chk("mid_reset_timeout", 32'(hz.mem_timeout), 32'd0);
        chk("mid_reset_stall_cnt", 32'(hz.stall_count), 32'd0);
        chk("mid_reset_flush_cnt", 32'(hz.flush_count), 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("rerun_state", 32'(hz.ctrl_state), 32'd1);

        // Continuous load-use: count to FFFE, then three more stalls must hold FFFF.
        hz.p2_memRead = 1'b1; hz.p2_mem_rd = 3'd3; hz.id_alu_rm = 3'd3; hz.id_src_valid = 4'b0010;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(hz.stall_count), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        chk("sat_ffff", 32'(hz.stall_count), 32'h0000_FFFF);
        chk("sat_ctrl", 32'(ctrl_vec()), 32'(C_LDUSE));
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 4-register VLIW pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Per cycle, drives every pipeline-register write enable and flush, the ID/EX control bubble and the PC write enable.
- Decisions come from load-use hazards between the EX-stage load and the ID bundle, branch/jump redirects resolved in EX, and the MEM-stage memory handshake.
- Sequences a post-reset flush window and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- INIT_FLUSH_CYCLES, 4, length of the post-reset flush window in cycles; 0 is treated as 1.
- FREEZE_TIMEOUT, 255, number of consecutive FREEZE cycles after which mem_timeout is set.
- CNT_WIDTH, 16, width of stall_count and flush_count.

Ports:
- Clocking and reset (fixed): one clock `clk`; reset `reset` is asynchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd  in  3 each  source register fields of the bundle in ID.
- id_src_valid  in  4  read-enables for those sources; bit0 alu_rn, bit1 alu_rm, bit2 mem_rn, bit3 mem_rd (store data).
- p2_memRead  in  1  a load is in EX.
- p2_mem_rd  in  3  destination register of the EX load.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- mem_req  in  1  MEM stage has a memory access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  pipeline-register write enables.
- IF_flush, ID_flush, EX_flush  out  1 each  flush controls to the IF/ID, ID/EX and EX/MEM registers.
- p2_pipeline_stall  out  1  inserts a bubble into the ID/EX control fields.
- ctrl_state  out  2  current state: 0 INIT, 1 RUN, 2 FREEZE.
- stall_count, flush_count  out  CNT_WIDTH each  saturating performance counters.
- mem_timeout  out  1  sticky error flag.

## Operation
States:
- INIT
  - Outputs: pc_write=0; all four stage writes=1; IF_flush=ID_flush=EX_flush=1; p2_pipeline_stall=0.
  - A down-counter is loaded with max(INIT_FLUSH_CYCLES,1) at reset and decrements each cycle.
  - When the counter is 1 on a clock edge, next state is RUN.
- RUN: outputs are combinational, evaluated in strict priority order.
  1. Freeze: mem_req & !mem_ready.
     - All writes=0, all flushes=0, p2_pipeline_stall=0.
     - Next state FREEZE; stall_count +1.
  2. Redirect: ex_redirect.
     - pc_write=1, all writes=1, IF_flush=1, ID_flush=1, EX_flush=0.
     - flush_count +1.
  3. Load-use: p2_memRead and p2_mem_rd equals any source whose id_src_valid bit is 1.
     - pc_write=0, if_id_write=0, p2_pipeline_stall=1, id_ex_write=ex_mem_write=mem_wb_write=1, flushes=0.
     - stall_count +1.
  4. Normal: pc_write=1, all writes=1, flushes=0, p2_pipeline_stall=0.
- FREEZE
  - While mem_ready=0: outputs as RUN item 1; stall_count +1 per cycle; the consecutive-freeze counter increments.
  - When mem_ready=1: outputs evaluated as RUN items 2-4 that cycle; next state RUN; freeze counter cleared.
  - When the freeze counter reaches FREEZE_TIMEOUT, mem_timeout is set and stays 1 until reset.
  - Freeze is never exited by a timeout.

Rules:
- Register r0 has no special meaning; every 3-bit match counts.
- Counters saturate at all-ones and never wrap.
- FREEZE→RUN exit cycle counts only its own redirect or load-use event.
- The ctrl_state encoding value 3 is unreachable; if entered, recover to INIT.

## Timing
- Reset values (asynchronous): state INIT, init counter = max(INIT_FLUSH_CYCLES,1), stall_count=0, flush_count=0, mem_timeout=0, freeze counter=0.
- During reset, outputs take their INIT values.
- Control outputs are combinational from the inputs and the registered state, so they take effect at the same edge as the hazard (zero latency).
- ctrl_state, counters and mem_timeout update on the edge after the event.
- First RUN cycle is INIT_FLUSH_CYCLES cycles after reset deassertion.
- Load-use costs exactly 1 bubble; the next cycle sees p2_memRead=0, so no re-stall.
- Simultaneous events:
  - redirect + load-use: redirect only, flush_count +1, stall_count unchanged.
  - freeze + redirect: freeze wins; the EX stage holds ex_redirect, and the redirect is taken on the exit cycle.
- Reset asserted mid-FREEZE or mid-INIT: immediate return to INIT; counters cleared.

## Test plan
- Reset release, INIT_FLUSH_CYCLES=4 → 4 cycles of pc_write=0 with IF/ID/EX flush=1, RUN on cycle 5, counters 0.
- p2_memRead=1, p2_mem_rd=3, id_alu_rm=3, id_src_valid=4'b0010 → one cycle pc_write=0, if_id_write=0, p2_pipeline_stall=1; stall_count=1.
- Same load with id_src_valid=4'b0000 → no stall.
- ex_redirect=1 together with a load-use match → IF_flush=ID_flush=1, pc_write=1, p2_pipeline_stall=0, flush_count=1, stall_count=0.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with ex_redirect=1 → 3 cycles of all writes 0, stall_count=3, flush on the exit cycle, state RUN afterwards.
- FREEZE_TIMEOUT=8, mem_ready held 0 for 10 cycles → mem_timeout rises after 8 FREEZE cycles, stays set after exit.
- Asserting reset in FREEZE → immediate INIT, mem_timeout=0.
- Force stall_count to 16'hFFFE, then 3 stalls → stall_count holds 16'hFFFF.
